// File: rtl/cyc3_seq_checker_if.sv
// Bus bundle for the cyclic-code checker: sampled stream and control in,
// lock/prediction/error status out.
interface cyc3_seq_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       in_code;
  logic             clr_count;
  logic             locked;
  logic [1:0]       expected;
  logic             err_pulse;
  logic             illegal_seen;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_code, clr_count,
    input  locked, expected, err_pulse, illegal_seen, err_count
  );

  modport slave (
    input  in_valid, in_code, clr_count,
    output locked, expected, err_pulse, illegal_seen, err_count
  );
endinterface

// File: rtl/cyc3_seq_checker.sv
// Receive-side checker for the 0->1->2->0 code stream: hunts, locks after
// LOCK_N good codes, flywheels through errors and unlocks after UNLOCK_N misses.
module cyc3_seq_checker #(
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  cyc3_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);

  state_t     state;
  logic [1:0] pred;
  logic [3:0] good_cnt;
  logic [3:0] bad_cnt;

  function automatic logic [1:0] succ(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // pred doubles as the registered expected output; it is forced to 0 in HUNT.
  assign bus.expected = pred;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= HUNT;
      pred             <= '0;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      bus.locked       <= 1'b0;
      bus.err_pulse    <= 1'b0;
      bus.illegal_seen <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      bus.err_pulse <= 1'b0;
      if (bus.in_valid) begin
        unique case (state)
          HUNT: begin
            if (bus.in_code == 2'd3) begin
              bus.illegal_seen <= 1'b1;
            end else begin
              pred     <= succ(bus.in_code);
              good_cnt <= 4'd1;
              state    <= SYNC;
            end
          end
          SYNC: begin
            if (bus.in_code == 2'd3) begin
              bus.illegal_seen <= 1'b1;
              pred             <= '0;
              good_cnt         <= '0;
              state            <= HUNT;
            end else if (bus.in_code == pred) begin
              good_cnt <= good_cnt + 4'd1;
              pred     <= succ(pred);
              if (good_cnt + 4'd1 == LOCK_V) begin
                state      <= LOCKED;
                bad_cnt    <= '0;
                bus.locked <= 1'b1;
              end
            end else begin
              pred     <= succ(bus.in_code);
              good_cnt <= 4'd1;
            end
          end
          LOCKED: begin
            if (bus.in_code == pred) begin
              pred    <= succ(pred);
              bad_cnt <= '0;
            end else begin
              bus.err_pulse <= 1'b1;
              if (bus.err_count != '1)
                bus.err_count <= bus.err_count + CNT_W'(1);
              if (bus.in_code == 2'd3)
                bus.illegal_seen <= 1'b1;
              if (bad_cnt + 4'd1 == UNLOCK_V) begin
                state      <= HUNT;
                bus.locked <= 1'b0;
                pred       <= '0;
                good_cnt   <= '0;
                bad_cnt    <= '0;
              end else begin
                bad_cnt <= bad_cnt + 4'd1;
                pred    <= succ(pred);
              end
            end
          end
          default: begin
            state <= HUNT;
            pred  <= '0;
          end
        endcase
      end
      // Clear wins over a same-cycle increment or illegal flag set.
      if (bus.clr_count) begin
        bus.err_count    <= '0;
        bus.illegal_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cyc3_seq_checker.sv
// Directed plus randomized bench for cyc3_seq_checker, compared against an
// arithmetic reference model; a second instance with a 2-bit counter covers saturation.
module tb_cyc3_seq_checker;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] code = '0;
  logic       clr = 1'b0;

  int checks = 0;
  int failures = 0;

  cyc3_seq_checker_if #(.CNT_W(8)) b8 ();
  cyc3_seq_checker_if #(.CNT_W(2)) b2 ();

  assign b8.in_valid  = valid;
  assign b8.in_code   = code;
  assign b8.clr_count = clr;
  assign b2.in_valid  = valid;
  assign b2.in_code   = code;
  assign b2.clr_count = clr;

  cyc3_seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8.slave));
  cyc3_seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave));

  always #5 clk = ~clk;

  // Reference model: mode 0 = hunting, 1 = synchronising, 2 = locked.
  int m_mode, m_pred, m_good, m_bad, m_errs, m_pulse, m_ill;

  task automatic model_reset();
    m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0;
    m_errs = 0; m_pulse = 0; m_ill = 0;
  endtask

  task automatic model_step(input int v, input int c, input int cl);
    m_pulse = 0;
    if (v != 0) begin
      if (m_mode == 0) begin
        if (c == 3) m_ill = 1;
        else begin m_pred = (c + 1) % 3; m_good = 1; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (c == 3) begin m_mode = 0; m_ill = 1; m_pred = 0; m_good = 0; end
        else if (c == m_pred) begin
          m_good++; m_pred = (m_pred + 1) % 3;
          if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else begin m_pred = (c + 1) % 3; m_good = 1; end
      end else begin
        if (c == m_pred) begin m_pred = (m_pred + 1) % 3; m_bad = 0; end
        else begin
          m_pulse = 1; m_errs++; m_bad++; m_pred = (m_pred + 1) % 3;
          if (c == 3) m_ill = 1;
          if (m_bad == UNLOCK_N) begin m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0; end
        end
      end
    end
    if (cl != 0) begin m_errs = 0; m_ill = 0; end
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "locked",       32'(b8.locked),       32'(m_mode == 2));
    chk(tag, "expected",     32'(b8.expected),     32'(m_pred));
    chk(tag, "err_pulse",    32'(b8.err_pulse),    32'(m_pulse));
    chk(tag, "illegal_seen", 32'(b8.illegal_seen), 32'(m_ill));
    chk(tag, "err_count8",   32'(b8.err_count),    32'((m_errs > 255) ? 255 : m_errs));
    chk(tag, "err_count2",   32'(b2.err_count),    32'((m_errs > 3) ? 3 : m_errs));
    chk(tag, "locked2",      32'(b2.locked),       32'(m_mode == 2));
  endtask

  task automatic step(input int v, input int c, input int cl, input string tag);
    @(negedge clk);
    valid = 1'(v); code = 2'(c); clr = 1'(cl);
    @(posedge clk);
    model_step(v, c, cl);
    #1 check_all(tag);
  endtask

  task automatic send_good(input string tag);
    step(1, m_pred, 0, tag);
  endtask

  task automatic send_bad(input string tag);
    step(1, (m_pred + 1) % 3, 0, tag);
  endtask

  initial begin
    int v, c, cl;
    model_reset();
    #12 reset_n = 1'b1;
    check_all("reset");

    // Lock on 0,1,2,0
    step(1, 0, 0, "t1"); step(1, 1, 0, "t1"); step(1, 2, 0, "t1");
    chk("t1", "not_yet_locked", 32'(b8.locked), 32'd0);
    step(1, 0, 0, "t1");
    chk("t1", "locked_fixed", 32'(b8.locked), 32'd1);
    chk("t1", "expected_fixed", 32'(b8.expected), 32'd1);

    // Align prediction to 0, then one isolated error with flywheel
    step(1, 1, 0, "t2"); step(1, 2, 0, "t2");
    step(1, 0, 0, "t2"); step(1, 1, 0, "t2");
    step(1, 1, 0, "t2");
    chk("t2", "pulse_fixed", 32'(b8.err_pulse), 32'd1);
    step(1, 0, 0, "t2"); step(1, 1, 0, "t2");
    chk("t2", "count_fixed", 32'(b8.err_count), 32'd1);
    chk("t2", "still_locked", 32'(b8.locked), 32'd1);

    // Three illegal codes drop lock
    step(0, 0, 1, "t3");
    step(1, 3, 0, "t3"); step(1, 3, 0, "t3"); step(1, 3, 0, "t3");
    chk("t3", "count_fixed", 32'(b8.err_count), 32'd3);
    chk("t3", "illegal_fixed", 32'(b8.illegal_seen), 32'd1);
    chk("t3", "unlocked_fixed", 32'(b8.locked), 32'd0);
    chk("t3", "expected_zero", 32'(b8.expected), 32'd0);

    // Reseed path: 0,1,0,1,2,0
    step(1, 0, 0, "t4"); step(1, 1, 0, "t4"); step(1, 0, 0, "t4");
    step(1, 1, 0, "t4"); step(1, 2, 0, "t4");
    chk("t4", "not_yet_locked", 32'(b8.locked), 32'd0);
    step(1, 0, 0, "t4");
    chk("t4", "locked_fixed", 32'(b8.locked), 32'd1);

    // Five errors, then clear coinciding with a mismatch
    step(0, 0, 1, "t5");
    for (int i = 0; i < 5; i++) begin
      send_bad("t5"); step(0, 0, 0, "t5_stall"); send_good("t5");
    end
    chk("t5", "count8_fixed", 32'(b8.err_count), 32'd5);
    chk("t5", "count2_sat", 32'(b2.err_count), 32'd3);
    step(1, (m_pred + 1) % 3, 1, "t5_clr");
    chk("t5", "pulse_on_clr", 32'(b8.err_pulse), 32'd1);
    chk("t5", "count_cleared", 32'(b8.err_count), 32'd0);

    // Asynchronous reset between edges
    @(negedge clk);
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_all("t6_async");
    #1 reset_n = 1'b1;
    step(1, 2, 0, "t6");
    chk("t6", "expected_after_seed", 32'(b8.expected), 32'd0);
    chk("t6", "locked_after_seed", 32'(b8.locked), 32'd0);

    // Randomized traffic biased toward the predicted code
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 99) < 75) ? 1 : 0;
      c  = ($urandom_range(0, 99) < 80) ? m_pred : int'($urandom_range(0, 3));
      cl = ($urandom_range(0, 99) < 3) ? 1 : 0;
      step(v, c, cl, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
